// File: rtl/jk_frontend_pkg.sv
// Shared types and command encodings for the JK command front end.
package jk_frontend_pkg;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        WAIT_PAIR = 2'd1,
        EMIT      = 2'd2
    } fsm_state_t;

    typedef enum logic {
        SET = 1'b0,
        CLR = 1'b1
    } first_ch_t;

    localparam logic [1:0] JK_HOLD = 2'b00;
    localparam logic [1:0] JK_CLR  = 2'b01;
    localparam logic [1:0] JK_SET  = 2'b10;
    localparam logic [1:0] JK_TOG  = 2'b11;

    // Command issued when the pairing window expires with no partner.
    function automatic logic [1:0] single_cmd(input first_ch_t ch);
        return (ch == SET) ? JK_SET : JK_CLR;
    endfunction

endpackage

// File: rtl/jk_debounce.sv
// One button channel: 2-flop synchronizer, stability counter and a
// registered one-cycle pulse on each debounced press.
module jk_debounce #(
    parameter int unsigned DEBOUNCE_CYCLES = 16
) (
    input  logic clk,
    input  logic rst,
    input  logic btn,
    output logic press
);

    localparam int unsigned CW = $clog2(DEBOUNCE_CYCLES);
    localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

    logic          sync1;
    logic          sync2;
    logic          level;
    logic [CW-1:0] cnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            sync1 <= 1'b0;
            sync2 <= 1'b0;
            level <= 1'b0;
            cnt   <= '0;
            press <= 1'b0;
        end else begin
            sync1 <= btn;
            sync2 <= sync1;
            press <= 1'b0;
            if (sync2 == level) begin
                cnt <= '0;
            end else if (cnt == CNT_LAST) begin
                // Level flips on the last mismatching cycle; only rises are events.
                level <= sync2;
                cnt   <= '0;
                press <= sync2;
            end else begin
                cnt <= cnt + CW'(1);
            end
        end
    end

endmodule

// File: rtl/jk_cmd_frontend.sv
// Turns two bouncy buttons into registered J/K commands: a paired press
// toggles, a lone press sets or clears after the pairing window expires.
module jk_cmd_frontend
    import jk_frontend_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = 16,
    parameter int unsigned PAIR_WINDOW     = 8
) (
    input  logic clk,
    input  logic rst,
    input  logic btn_set,
    input  logic btn_clr,
    output logic j,
    output logic k,
    output logic cmd_strobe,
    output logic busy
);

    localparam int unsigned WW = $clog2(PAIR_WINDOW + 1);
    localparam logic [WW-1:0] WIN_LAST = WW'(PAIR_WINDOW - 1);

    logic       set_press;
    logic       clr_press;
    fsm_state_t state;
    first_ch_t  first;
    logic [WW-1:0] win;
    logic       partner;

    jk_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_set (
        .clk   (clk),
        .rst   (rst),
        .btn   (btn_set),
        .press (set_press)
    );

    jk_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_clr (
        .clk   (clk),
        .rst   (rst),
        .btn   (btn_clr),
        .press (clr_press)
    );

    assign partner = (first == SET) ? clr_press : set_press;

    // Outputs are loaded on the transition into EMIT so they line up with it.
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            first      <= SET;
            win        <= '0;
            j          <= 1'b0;
            k          <= 1'b0;
            cmd_strobe <= 1'b0;
            busy       <= 1'b0;
        end else begin
            j          <= 1'b0;
            k          <= 1'b0;
            cmd_strobe <= 1'b0;
            unique case (state)
                IDLE: begin
                    busy <= 1'b0;
                    if (set_press && clr_press) begin
                        state      <= EMIT;
                        {j, k}     <= JK_TOG;
                        cmd_strobe <= 1'b1;
                        busy       <= 1'b1;
                    end else if (set_press || clr_press) begin
                        state <= WAIT_PAIR;
                        first <= set_press ? SET : CLR;
                        win   <= '0;
                        busy  <= 1'b1;
                    end
                end
                WAIT_PAIR: begin
                    busy <= 1'b1;
                    if (partner) begin
                        state      <= EMIT;
                        {j, k}     <= JK_TOG;
                        cmd_strobe <= 1'b1;
                    end else if (win == WIN_LAST) begin
                        state      <= EMIT;
                        {j, k}     <= single_cmd(first);
                        cmd_strobe <= 1'b1;
                    end else begin
                        win <= win + WW'(1);
                    end
                end
                EMIT: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule
